frame_swap_ctrl: RTL and testbench



---
 rtl/frame_swap_ctrl_if.sv | 25 ++
 rtl/frame_swap_ctrl.sv | 151 +++++++++++++++
 tb/tb_frame_swap_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/frame_swap_ctrl_if.sv
// Local-bus register window interface for frame_swap_ctrl.
// The master drives accesses; the slave returns combinational read data.
interface frame_swap_ctrl_if;
    logic        ctrl_sel;
    logic [3:0]  local_addr;
    logic        local_wr;
    logic [31:0] local_wr_data;
    logic [31:0] local_rd_data;

    modport master (
        output ctrl_sel,
        output local_addr,
        output local_wr,
        output local_wr_data,
        input  local_rd_data
    );

    modport slave (
        input  ctrl_sel,
        input  local_addr,
        input  local_wr,
        input  local_wr_data,
        output local_rd_data
    );
endinterface

// File: rtl/frame_swap_ctrl.sv
// Double-buffer bank controller: defers software swap requests to the scanner's frame boundary.
// Optional level interrupt enabled by defining FRAME_SWAP_IRQ_EN.
module frame_swap_ctrl #(
    parameter int unsigned MIN_FRAMES = 1,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                axi_clk,
    input  logic                axi_rst,
    frame_swap_ctrl_if.slave    bus,
    input  logic                frame_done,
    output logic                front_bank,
    output logic                back_bank,
    output logic                swap_pending,
    output logic                irq
);

    typedef enum logic [0:0] {StIdle, StPending} state_e;

    state_e             r_state;
    state_e             w_state_next;
    logic               r_front;
    logic               r_auto;
    logic               r_swap_done;
    logic               r_overrun;
    logic [7:0]         r_frames_since;
    logic [CNT_W-1:0]   r_frame_cnt;
    logic [CNT_W-1:0]   r_swap_cnt;
    logic               w_irq_en;

    logic               w_wr;
    logic               w_wr_ctrl;
    logic               w_wr_stat;
    logic               w_swap_req;
    logic               w_eligible;
    logic               w_swap;
    logic               w_overrun_set;
    logic               w_unused_bits;

    assign w_wr          = bus.ctrl_sel && bus.local_wr;
    assign w_wr_ctrl     = w_wr && (bus.local_addr[3:2] == 2'd0);
    assign w_wr_stat     = w_wr && (bus.local_addr[3:2] == 2'd1);
    assign w_swap_req    = w_wr_ctrl && bus.local_wr_data[0];
    assign w_eligible    = frame_done &&
                           (({1'b0, r_frames_since} + 9'd1) >= 9'(MIN_FRAMES));
    assign w_swap        = w_eligible && (r_state == StPending);
    // A request landing on the swap cycle becomes a fresh request, not an overrun.
    assign w_overrun_set = w_swap_req && (r_state == StPending) && !w_swap;
    assign w_unused_bits = ^{bus.local_wr_data[31:4], bus.local_addr[1:0]};

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_swap_req || (frame_done && r_auto)) begin
                    w_state_next = StPending;
                end
            end
            StPending: begin
                // AUTO keeps the FSM armed so every eligible frame swaps.
                if (w_swap && !w_swap_req && !r_auto) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            r_front        <= 1'b0;
            r_auto         <= 1'b0;
            r_swap_done    <= 1'b0;
            r_overrun      <= 1'b0;
            r_frames_since <= 8'd0;
            r_frame_cnt    <= '0;
            r_swap_cnt     <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_auto <= bus.local_wr_data[1];
            end
            if (w_swap) begin
                r_front        <= ~r_front;
                r_swap_cnt     <= r_swap_cnt + CNT_W'(1);
                r_frames_since <= 8'd0;
            end else if (frame_done && (r_frames_since != 8'hFF)) begin
                r_frames_since <= r_frames_since + 8'd1;
            end
            if (frame_done) begin
                r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            end
            if (w_swap) begin
                r_swap_done <= 1'b1;
            end else if (w_wr_stat && bus.local_wr_data[2]) begin
                r_swap_done <= 1'b0;
            end
            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end else if (w_wr_stat && bus.local_wr_data[3]) begin
                r_overrun <= 1'b0;
            end
        end
    end

`ifdef FRAME_SWAP_IRQ_EN
    logic r_irq_en;
    logic r_irq;

    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_irq_en <= bus.local_wr_data[2];
            end
            r_irq <= r_irq_en && (r_swap_done || r_overrun);
        end
    end

    assign w_irq_en = r_irq_en;
    assign irq      = r_irq;
`else
    assign w_irq_en = 1'b0;
    assign irq      = 1'b0;
`endif

    always_comb begin
        bus.local_rd_data = 32'd0;
        unique case (bus.local_addr[3:2])
            2'd0: bus.local_rd_data = {29'd0, w_irq_en, r_auto, 1'b0};
            2'd1: bus.local_rd_data = {28'd0, r_overrun, r_swap_done,
                                       (r_state == StPending), r_front};
            2'd2: bus.local_rd_data = 32'(r_frame_cnt);
            2'd3: bus.local_rd_data = 32'(r_swap_cnt);
            default: bus.local_rd_data = 32'd0;
        endcase
    end

    assign front_bank   = r_front;
    assign back_bank    = ~r_front;
    assign swap_pending = (r_state == StPending);

endmodule

// File: tb/tb_frame_swap_ctrl.sv
// Scoreboard bench for frame_swap_ctrl: DUT A uses MIN_FRAMES=1, DUT B uses MIN_FRAMES=3.
module tb_frame_swap_ctrl;

`ifdef FRAME_SWAP_IRQ_EN
    localparam bit IrqOn = 1'b1;
`else
    localparam bit IrqOn = 1'b0;
`endif

    typedef struct {
        string       name;
        int          kind;   // 0 = register read, 1 = pins {irq, pending, back, front}
        int          d;
        logic [31:0] exp;
    } chk_t;

    chk_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic axi_clk = 1'b0;
    logic axi_rst = 1'b1;
    logic fd_a = 1'b0, fd_b = 1'b0;
    logic front_a, back_a, pend_a, irq_a;
    logic front_b, back_b, pend_b, irq_b;

    frame_swap_ctrl_if bus_a ();
    frame_swap_ctrl_if bus_b ();

    frame_swap_ctrl #(.MIN_FRAMES(1), .CNT_W(32)) u_dut_a (
        .axi_clk      (axi_clk),
        .axi_rst      (axi_rst),
        .bus          (bus_a),
        .frame_done   (fd_a),
        .front_bank   (front_a),
        .back_bank    (back_a),
        .swap_pending (pend_a),
        .irq          (irq_a)
    );

    frame_swap_ctrl #(.MIN_FRAMES(3), .CNT_W(32)) u_dut_b (
        .axi_clk      (axi_clk),
        .axi_rst      (axi_rst),
        .bus          (bus_b),
        .frame_done   (fd_b),
        .front_bank   (front_b),
        .back_bank    (back_b),
        .swap_pending (pend_b),
        .irq          (irq_b)
    );

    always #5 axi_clk = ~axi_clk;

    // Monitor: compare every queued expectation against the outputs of this cycle.
    always @(negedge axi_clk) begin : mon
        chk_t        c;
        logic [31:0] act;
        while (q.size() > 0) begin
            c = q.pop_front();
            if (c.kind == 0) begin
                act = (c.d == 0) ? bus_a.local_rd_data : bus_b.local_rd_data;
            end else begin
                act = (c.d == 0) ? {28'd0, irq_a, pend_a, back_a, front_a}
                                 : {28'd0, irq_b, pend_b, back_b, front_b};
            end
            n_tests++;
            if (act !== c.exp) begin
                n_fail++;
                $display("FAIL %s: actual=0x%0h required=0x%0h", c.name, act, c.exp);
            end
        end
    end

    task automatic step();
        @(posedge axi_clk);
        #1;
        bus_a.ctrl_sel = 1'b0; bus_a.local_wr = 1'b0;
        bus_b.ctrl_sel = 1'b0; bus_b.local_wr = 1'b0;
        fd_a = 1'b0;
        fd_b = 1'b0;
    endtask

    task automatic wr(input int d, input logic [3:0] a, input logic [31:0] v);
        if (d == 0) begin
            bus_a.ctrl_sel = 1'b1; bus_a.local_wr = 1'b1;
            bus_a.local_addr = a;  bus_a.local_wr_data = v;
        end else begin
            bus_b.ctrl_sel = 1'b1; bus_b.local_wr = 1'b1;
            bus_b.local_addr = a;  bus_b.local_wr_data = v;
        end
    endtask

    task automatic rd_exp(input int d, input logic [3:0] a, input logic [31:0] e,
                          input string n);
        chk_t c;
        if (d == 0) bus_a.local_addr = a;
        else        bus_b.local_addr = a;
        c.name = n; c.kind = 0; c.d = d; c.exp = e;
        q.push_back(c);
    endtask

    task automatic pin_exp(input int d, input logic [3:0] e, input string n);
        chk_t c;
        c.name = n; c.kind = 1; c.d = d; c.exp = {28'd0, e};
        q.push_back(c);
    endtask

    task automatic pulse(input int d);
        if (d == 0) fd_a = 1'b1;
        else        fd_b = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus_a.ctrl_sel = 1'b0; bus_a.local_wr = 1'b0;
        bus_a.local_addr = 4'h0; bus_a.local_wr_data = 32'd0;
        bus_b.ctrl_sel = 1'b0; bus_b.local_wr = 1'b0;
        bus_b.local_addr = 4'h0; bus_b.local_wr_data = 32'd0;
        axi_rst = 1'b1;
        step(); step();
        axi_rst = 1'b0;
        step();

        // Reset values on both instances.
        for (int i = 0; i < 4; i++) begin
            rd_exp(0, 4'(i * 4), 32'd0, $sformatf("a_reg%0d_rst", i));
            rd_exp(1, 4'(i * 4), 32'd0, $sformatf("b_reg%0d_rst", i));
            if (i == 0) begin
                pin_exp(0, 4'b0010, "a_pins_rst");
                pin_exp(1, 4'b0010, "b_pins_rst");
            end
            step();
        end

        // Software swap deferred to frame_done, 1-cycle latency.
        wr(0, 4'h0, 32'h1); step();
        pin_exp(0, 4'b0110, "a_req_pending"); step();
        repeat (3) step();
        pulse(0); pin_exp(0, 4'b0110, "a_pending_hold"); step();
        pin_exp(0, 4'b0001, "a_swap_1cyc");
        rd_exp(0, 4'h4, 32'h5, "a_status_done"); step();
        rd_exp(0, 4'hC, 32'd1, "a_swap_cnt1"); step();
        rd_exp(0, 4'h8, 32'd1, "a_frame_cnt1"); step();
        rd_exp(0, 4'h0, 32'd0, "a_ctrl_req_reads0"); step();

        // Double request: overrun, single swap, W1C.
        wr(0, 4'h0, 32'h1); step();
        wr(0, 4'h0, 32'h1); step();
        rd_exp(0, 4'h4, 32'hF, "a_status_overrun"); step();
        pulse(0); step();
        pin_exp(0, 4'b0010, "a_overrun_one_swap");
        rd_exp(0, 4'hC, 32'd2, "a_swap_cnt2"); step();
        pulse(0); step();
        pin_exp(0, 4'b0010, "a_idle_fd_noswap");
        rd_exp(0, 4'hC, 32'd2, "a_swap_cnt_still2"); step();
        wr(0, 4'h4, 32'h8); step();
        rd_exp(0, 4'h4, 32'h4, "a_overrun_w1c"); step();
        rd_exp(0, 4'h8, 32'd3, "a_frame_cnt3"); step();
        wr(0, 4'h8, 32'hFFFF); step();
        rd_exp(0, 4'h8, 32'd3, "a_frame_cnt_ro"); step();

        // MIN_FRAMES=3 rate limit on DUT B.
        wr(1, 4'h0, 32'h1); step();
        for (int k = 0; k < 3; k++) begin
            pulse(1); step();
            pin_exp(1, (k < 2) ? 4'b0110 : 4'b0001, $sformatf("b_first_fd%0d", k)); step();
        end
        wr(1, 4'h0, 32'h1); step();
        for (int k = 0; k < 3; k++) begin
            pulse(1); step();
            pin_exp(1, (k < 2) ? 4'b0101 : 4'b0010, $sformatf("b_second_fd%0d", k)); step();
        end
        rd_exp(1, 4'h8, 32'd6, "b_frame_cnt6"); step();
        rd_exp(1, 4'hC, 32'd2, "b_swap_cnt2"); step();

        // AUTO mode: first frame arms, following frames swap.
        axi_rst = 1'b1; step();
        axi_rst = 1'b0; step();
        wr(0, 4'h0, 32'h2); step();
        rd_exp(0, 4'h0, 32'h2, "a_ctrl_auto"); step();
        pulse(0); step();
        pin_exp(0, 4'b0110, "a_auto_arm"); step();
        for (int k = 0; k < 4; k++) begin
            pulse(0); step();
            pin_exp(0, (k % 2 == 0) ? 4'b0101 : 4'b0110, $sformatf("a_auto_swap%0d", k));
            step();
        end
        rd_exp(0, 4'hC, 32'd4, "a_auto_swap_cnt4"); step();
        rd_exp(0, 4'h8, 32'd5, "a_auto_frame_cnt5"); step();

        // Simultaneous events, interrupt, reset mid-pending.
        axi_rst = 1'b1; step();
        axi_rst = 1'b0; step();
        wr(0, 4'h0, 32'h5); pulse(0); step();
        pin_exp(0, 4'b0110, "a_req_fd_same");
        rd_exp(0, 4'h0, IrqOn ? 32'h4 : 32'h0, "a_ctrl_irq_en"); step();
        wr(0, 4'h0, 32'h5); pulse(0); step();
        pin_exp(0, 4'b0101, "a_swap_req_same");
        rd_exp(0, 4'h4, 32'h7, "a_status_swap_req_same"); step();
        pin_exp(0, IrqOn ? 4'b1101 : 4'b0101, "a_irq_set"); step();
        wr(0, 4'h4, 32'h4); step();
        rd_exp(0, 4'h4, 32'h3, "a_status_done_w1c"); step();
        pin_exp(0, 4'b0101, "a_irq_clr"); step();
        axi_rst = 1'b1; step();
        pin_exp(0, 4'b0010, "a_rst_mid_pend");
        rd_exp(0, 4'h4, 32'h0, "a_status_rst");
        axi_rst = 1'b0; step();
        step();

        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: actual=%0d required=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
